// File: rtl/multi_pulse_generator.sv
// multi_pulse_generator: per-channel synchronized edge trigger producing fixed-width pulses with holdoff and sticky miss flags
module multi_pulse_generator #(
    parameter int N_CHANNELS  = 4,
    parameter int CNT_WIDTH   = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [N_CHANNELS-1:0] in_signal,
    input  logic [1:0]            edge_mode,
    input  logic [CNT_WIDTH-1:0]  pulse_len,
    input  logic [CNT_WIDTH-1:0]  holdoff_len,
    input  logic                  clr_missed,
    output logic [N_CHANNELS-1:0] out_signal,
    output logic [N_CHANNELS-1:0] busy,
    output logic [N_CHANNELS-1:0] missed
);
    typedef enum logic [1:0] {IDLE, PULSE, HOLDOFF} state_t;
    genvar c;
    generate
        for (c = 0; c < N_CHANNELS; c++) begin : g_ch
            logic [SYNC_STAGES-1:0] sync;
            logic                   prev, det, trig, miss, out_r, busy_r, missed_r, out_n, busy_n;
            logic [CNT_WIDTH-1:0]   cnt, cnt_n, hold, hold_n;
            state_t                 state, state_n;
            assign trig = (edge_mode[0] & sync[SYNC_STAGES-1] & ~prev) |
                          (edge_mode[1] & ~sync[SYNC_STAGES-1] & prev);
            assign miss = det & (state != IDLE);
            assign out_signal[c] = out_r;
            assign busy[c]       = busy_r;
            assign missed[c]     = missed_r;
            // synchronizer, edge history and registered trigger detection
            always_ff @(posedge clk) begin
                if (rst) begin
                    sync <= '0;
                    prev <= 1'b0;
                    det  <= 1'b0;
                end else begin
                    sync <= {sync[SYNC_STAGES-2:0], in_signal[c]};
                    prev <= sync[SYNC_STAGES-1];
                    det  <= trig;
                end
            end
            // state, counters, registered outputs and sticky miss flag
            always_ff @(posedge clk) begin
                if (rst) begin
                    state    <= IDLE;
                    cnt      <= '0;
                    hold     <= '0;
                    out_r    <= 1'b0;
                    busy_r   <= 1'b0;
                    missed_r <= 1'b0;
                end else begin
                    state    <= state_n;
                    cnt      <= cnt_n;
                    hold     <= hold_n;
                    out_r    <= out_n;
                    busy_r   <= busy_n;
                    missed_r <= miss | (missed_r & ~clr_missed);
                end
            end
            // next state: settings are latched at trigger acceptance so later changes never touch a running pulse
            always_comb begin
                state_n = state;
                cnt_n   = cnt;
                hold_n  = hold;
                case (state)
                    IDLE: begin
                        if (det) begin
                            state_n = PULSE;
                            cnt_n   = (pulse_len == '0) ? CNT_WIDTH'(1) : pulse_len;
                            hold_n  = holdoff_len;
                        end
                    end
                    PULSE: begin
                        state_n = (cnt > CNT_WIDTH'(1)) ? PULSE : ((hold == '0) ? IDLE : HOLDOFF);
                        cnt_n   = (cnt > CNT_WIDTH'(1)) ? cnt - CNT_WIDTH'(1) : hold;
                    end
                    HOLDOFF: begin
                        state_n = (cnt > CNT_WIDTH'(1)) ? HOLDOFF : IDLE;
                        cnt_n   = (cnt > CNT_WIDTH'(1)) ? cnt - CNT_WIDTH'(1) : '0;
                    end
                    default: state_n = IDLE;
                endcase
            end
            // outputs follow the state being entered so they are registered alongside it
            always_comb begin
                out_n  = (state_n == PULSE);
                busy_n = (state_n != IDLE);
            end
        end
    endgenerate
endmodule

// File: tb/tb_multi_pulse_generator.sv
// tb_multi_pulse_generator: directed and random checks against an interval-based pulse model
module tb_multi_pulse_generator;
    localparam int N = 4;
    localparam int W = 8;
    localparam int MAXE = 4096;

    logic         clk = 1'b0;
    logic         rst;
    logic [N-1:0] in_sig;
    logic [1:0]   mode;
    logic [W-1:0] pl, hl;
    logic         clr;
    logic [N-1:0] out_signal, busy, missed;

    int total = 0;
    int bad = 0;

    int e = 0;
    int rst_edge = 0;
    logic [N-1:0] samp [0:MAXE-1];
    logic [N-1:0] detv [0:MAXE-1];
    int pstart [N];
    int pend [N];
    int bend [N];
    logic [N-1:0] mis;
    logic [N-1:0] exp_out, exp_busy;

    multi_pulse_generator #(.N_CHANNELS(N), .CNT_WIDTH(W), .SYNC_STAGES(2)) dut (
        .clk(clk), .rst(rst), .in_signal(in_sig), .edge_mode(mode),
        .pulse_len(pl), .holdoff_len(hl), .clr_missed(clr),
        .out_signal(out_signal), .busy(busy), .missed(missed)
    );

    always #5 clk = ~clk;

    function automatic logic lv(int c, int k);
        return (k <= rst_edge || k < 0) ? 1'b0 : samp[k][c];
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s e=%0d got=%0h exp=%0h", tag, e, got, exp);
        end
    endtask

    task automatic step();
        logic r, f, d, m;
        int p;
        @(posedge clk);
        e++;
        if (rst) begin
            rst_edge = e;
            samp[e] = '0;
            detv[e] = '0;
            mis = '0;
            for (int c = 0; c < N; c++) begin
                pstart[c] = e;
                pend[c] = e;
                bend[c] = e;
            end
        end else begin
            samp[e] = in_sig;
            for (int c = 0; c < N; c++) begin
                r = lv(c, e-2) & ~lv(c, e-3);
                f = ~lv(c, e-2) & lv(c, e-3);
                d = (mode[0] & r) | (mode[1] & f);
                detv[e][c] = d;
                m = 1'b0;
                if (detv[e-1][c]) begin
                    if (bend[c] <= e-1) begin
                        p = (pl == 0) ? 1 : int'(pl);
                        pstart[c] = e;
                        pend[c] = e + p;
                        bend[c] = e + p + int'(hl);
                    end else m = 1'b1;
                end
                mis[c] = m | (mis[c] & ~clr);
            end
        end
        for (int c = 0; c < N; c++) begin
            exp_out[c] = (pstart[c] <= e) && (e < pend[c]);
            exp_busy[c] = (pstart[c] <= e) && (e < bend[c]);
        end
        #1;
        chk("out_signal", 32'(out_signal), 32'(exp_out));
        chk("busy", 32'(busy), 32'(exp_busy));
        chk("missed", 32'(missed), 32'(mis));
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        rst = 1'b1; in_sig = '0; mode = 2'b00; pl = '0; hl = '0; clr = 1'b0;
        steps(2);
        chk("reset_out", 32'(out_signal), 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_missed", 32'(missed), 32'd0);
        rst = 1'b0;
        steps(2);
        mode = 2'b01; pl = 8'd5; hl = 8'd0;
        in_sig[0] = 1'b1;
        for (int k = 0; k <= 9; k++) begin
            step();
            chk("latency_out0", 32'(out_signal[0]), 32'(k >= 3 && k <= 7));
            chk("latency_busy0", 32'(busy[0]), 32'(k >= 3 && k <= 7));
        end
        in_sig[0] = 1'b0;
        steps(6);
        mode = 2'b11; pl = 8'd2; hl = 8'd0;
        in_sig[1] = 1'b1;
        steps(10);
        in_sig[1] = 1'b0;
        steps(10);
        chk("both_edges_missed1", 32'(missed[1]), 32'd0);
        mode = 2'b01; pl = 8'd4; hl = 8'd6;
        in_sig[2] = 1'b1;
        steps(3);
        in_sig[2] = 1'b0;
        step();
        in_sig[2] = 1'b1;
        steps(30);
        chk("holdoff_missed2", 32'(missed[2]), 32'd1);
        pl = 8'd0; hl = 8'd0;
        in_sig[3] = 1'b1;
        steps(8);
        mode = 2'b00;
        for (int k = 0; k < 20; k++) begin
            in_sig = N'($urandom);
            step();
            if (k >= 4) chk("mode00_out", 32'(out_signal), 32'd0);
        end
        in_sig = '0;
        steps(6);
        mode = 2'b01; pl = 8'd8; hl = 8'd3;
        steps(2);
        in_sig[0] = 1'b1;
        steps(6);
        chk("pre_rst_out0", 32'(out_signal[0]), 32'd1);
        rst = 1'b1;
        step();
        chk("mid_rst_out", 32'(out_signal), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        rst = 1'b0;
        steps(20);
        pl = 8'd3; hl = 8'd5;
        in_sig[1] = 1'b1;
        steps(4);
        in_sig[1] = 1'b0;
        step();
        in_sig[1] = 1'b1;
        steps(3);
        clr = 1'b1;
        step();
        chk("clr_vs_miss", 32'(missed[1]), 32'd1);
        clr = 1'b0;
        steps(15);
        clr = 1'b1;
        step();
        chk("clr_alone", 32'(missed[1]), 32'd0);
        clr = 1'b0;
        for (int k = 0; k < 400; k++) begin
            in_sig = ($urandom_range(0, 3) == 0) ? N'($urandom) : in_sig;
            if ($urandom_range(0, 15) == 0) mode = 2'($urandom);
            pl = W'($urandom_range(0, 6));
            hl = W'($urandom_range(0, 5));
            clr = ($urandom_range(0, 7) == 0);
            rst = ($urandom_range(0, 63) == 0);
            step();
        end
        rst = 1'b0; clr = 1'b0;
        steps(4);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
